// File: rtl/rv_uart_tx.sv
`default_nettype none
// ============================================================================
// rv_uart_tx : memory-mapped 8N1 UART transmitter with a small TX FIFO
// Revision   : 1.0 - initial release
// ============================================================================
module rv_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dout,
  input  logic        drw,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int                 PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                 CNT_W     = PTR_W + 1;
  localparam logic [15:0]        BAUD_LOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             tx_q, tx_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [15:0]      baud_q, baud_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             wr_prev_q, wr_prev_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];

  logic        sel;
  logic        wr_now;
  logic        wr_evt;
  logic        data_wr;
  logic        stat_wr;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [31:0] status;
  logic        unused_ok;

  assign sel        = (daddr[13:12] == 2'b10);
  assign wr_now     = drw & sel;
  assign wr_evt     = wr_now & ~wr_prev_q;
  assign data_wr    = wr_evt & ~daddr[2];
  assign stat_wr    = wr_evt & daddr[2];
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign push       = data_wr & ~fifo_full;
  assign wr_prev_d  = wr_now;
  assign unused_ok  = ^{daddr[31:14], daddr[11:3], daddr[1:0], dout[31:8]};

  // Count field is 4 bits wide; a 16-deep FIFO reports full via bit0 only.
  assign status = {24'd0, 4'(count_q), overflow_q, (state_q != ST_IDLE),
                   fifo_empty, fifo_full};

  always_comb begin
    rdata_d = '0;
    if (sel && daddr[2]) begin
      rdata_d = status;
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (data_wr && fifo_full) begin
      overflow_d = 1'b1;
    end else if (stat_wr && dout[3]) begin
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    baud_d    = baud_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    pop       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = BAUD_LOAD;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_q == 16'd0) begin
          state_d   = ST_DATA;
          baud_d    = BAUD_LOAD;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_q == 16'd0) begin
          baud_d = BAUD_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            // tx takes the next bit now, so the register shifts in step.
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_q == 16'd0) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = dout[7:0];
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      rdata_q    <= '0;
      baud_q     <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      wr_prev_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rdata_q    <= rdata_d;
      baud_q     <= baud_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      wr_prev_q  <= wr_prev_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign tx    = tx_q;
  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_rv_uart_tx : directed self-checking bench for rv_uart_tx (4 clks/bit)
// Revision      : 1.0 - initial release
// ============================================================================
module tb_rv_uart_tx;

  localparam int CPB = 4;
  localparam int FD  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] dout;
  logic        drw;
  logic [31:0] rdata;
  logic        tx;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        mon_en   = 1'b0;
  logic [7:0]  rx_q [$];
  logic [7:0]  exp_bytes [6];
  logic [9:0]  frame;
  logic        seen_low;

  always #5 clk = ~clk;

  rv_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (FD)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .daddr (daddr),
    .dout  (dout),
    .drw   (drw),
    .rdata (rdata),
    .tx    (tx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_toggle(input logic [31:0] a, input logic [31:0] d);
    daddr = a;
    dout  = d;
    drw   = 1'b1;
    tick();
    drw   = 1'b0;
    tick();
  endtask

  // Serial receiver: samples each bit at its middle cycle.
  initial begin : rx_monitor
    logic [7:0] b;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en && tx === 1'b0) begin
        repeat (6) @(posedge clk);
        #2;
        b[0] = tx;
        for (int j = 1; j < 8; j++) begin
          repeat (4) @(posedge clk);
          #2;
          b[j] = tx;
        end
        repeat (4) @(posedge clk);
        #2;
        chk("rx_stop", {31'd0, tx}, 32'd1);
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    exp_bytes = '{8'h31, 8'hC2, 8'h0F, 8'hF0, 8'h96, 8'hC8};
    reset = 1'b1;
    drw   = 1'b0;
    daddr = 32'h0;
    dout  = 32'h0;
    tick();
    tick();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_rdata", rdata, 32'h0);
    reset  = 1'b0;
    mon_en = 1'b1;

    daddr = 32'h0000_2004;
    tick();
    chk("status_after_rst", rdata, 32'h0000_0002);
    daddr = 32'h0000_1004;
    tick();
    chk("unselected_read", rdata, 32'h0);

    // Single byte, drw held three cycles.
    daddr = 32'h0000_2000;
    dout  = 32'h0000_0055;
    drw   = 1'b1;
    tick();
    chk("tx_before_pop", {31'd0, tx}, 32'd1);
    tick();
    frame = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("frame55_c%0d", i), {31'd0, tx}, {31'd0, frame[i/4]});
      if (i == 1) drw = 1'b0;
      tick();
    end
    daddr = 32'h0000_2004;
    tick();
    chk("idle_status", rdata, 32'h0000_0002);
    repeat (6) tick();
    chk("no_second_frame", {31'd0, tx}, 32'd1);
    chk("rx55_count", 32'(rx_q.size()), 32'd1);
    chk("rx55_byte", {24'd0, rx_q[0]}, 32'h55);
    rx_q.delete();

    // Five toggled writes, then overflow set/clear and drop on the pop edge.
    wr_toggle(32'h2000, 32'h31);
    wr_toggle(32'h2000, 32'hC2);
    wr_toggle(32'h2000, 32'h0F);
    wr_toggle(32'h2000, 32'hF0);
    wr_toggle(32'h2000, 32'h96);
    daddr = 32'h0000_2004;
    tick();
    chk("full_status", rdata, 32'h0000_0045);
    wr_toggle(32'h2000, 32'hA6);
    daddr = 32'h0000_2004;
    tick();
    chk("overflow_set", rdata, 32'h0000_004D);
    dout = 32'h8;
    drw  = 1'b1;
    tick();
    drw  = 1'b0;
    tick();
    chk("ovf_clear1", rdata, 32'h0000_0045);
    repeat (26) tick();
    chk("idle_before_pop", {31'd0, tx}, 32'd1);
    daddr = 32'h0000_2000;
    dout  = 32'hB7;
    drw   = 1'b1;
    tick();
    chk("pop_edge_start", {31'd0, tx}, 32'd0);
    drw   = 1'b0;
    daddr = 32'h0000_2004;
    tick();
    chk("drop_on_pop", rdata, 32'h0000_003C);
    dout = 32'h8;
    drw  = 1'b1;
    tick();
    drw  = 1'b0;
    tick();
    chk("ovf_clear2", rdata, 32'h0000_0034);

    // Push coinciding with a pop keeps the count.
    repeat (37) tick();
    daddr = 32'h0000_2000;
    dout  = 32'hC8;
    drw   = 1'b1;
    tick();
    chk("pushpop_start", {31'd0, tx}, 32'd0);
    drw   = 1'b0;
    daddr = 32'h0000_2004;
    tick();
    chk("pushpop_count", rdata, 32'h0000_0034);
    repeat (170) tick();
    chk("drained_status", rdata, 32'h0000_0002);
    chk("rx_order_count", 32'(rx_q.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rx_order_%0d", k), {24'd0, rx_q[k]}, {24'd0, exp_bytes[k]});
    end
    rx_q.delete();

    // Reset during data bit 3 with two bytes queued.
    mon_en = 1'b0;
    wr_toggle(32'h2000, 32'hF7);
    wr_toggle(32'h2000, 32'h5A);
    wr_toggle(32'h2000, 32'hA5);
    repeat (12) tick();
    chk("bit3_low", {31'd0, tx}, 32'd0);
    reset = 1'b1;
    tick();
    chk("rst_midframe_tx", {31'd0, tx}, 32'd1);
    reset = 1'b0;
    daddr = 32'h0000_2004;
    tick();
    chk("rst_midframe_status", rdata, 32'h0000_0002);
    seen_low = 1'b0;
    repeat (60) begin
      tick();
      if (tx !== 1'b1) seen_low = 1'b1;
    end
    chk("no_tx_after_rst", {31'd0, seen_low}, 32'd0);

    // drw held across reset release: no push during reset, one push after.
    daddr = 32'h0000_2000;
    dout  = 32'h3C;
    drw   = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_rdata2", rdata, 32'h0);
    mon_en = 1'b1;
    reset  = 1'b0;
    tick();
    tick();
    chk("held_drw_push", {31'd0, tx}, 32'd0);
    tick();
    tick();
    drw   = 1'b0;
    daddr = 32'h0000_2004;
    tick();
    chk("single_push", rdata, 32'h0000_0006);
    repeat (50) tick();
    chk("rx3c_count", 32'(rx_q.size()), 32'd1);
    chk("rx3c_byte", {24'd0, rx_q[0]}, 32'h3C);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv_uart_tx.md
RV_UART_TX -- requirements
Module: rv_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  single system clock (core clock); all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 daddr  input  32  core data address; block is selected when daddr[13:12]==2'b10.
REQ-006 dout  input  32  core write data.
REQ-007 drw  input  1  core write strobe, level; may stay high for several consecutive cycles per store.
REQ-008 rdata  output  32  registered read data, merged into core din by the top level.
REQ-009 tx  output  1  serial line, 8N1, LSB first, idle high.

Function
REQ-010 Register map, selected by daddr[2] when the block is selected: 0 = DATA (write-only, reads 0); 1 = STATUS.
REQ-011 STATUS layout: bit0 fifo_full; bit1 fifo_empty; bit2 busy (FSM not IDLE); bit3 overflow (sticky); bits[7:4] fifo count; bits[31:8] zero.
REQ-012 Read path: rdata is registered every cycle from the current daddr; latency is 1 cycle, the same as data BRAM; rdata is 0 when the block is not selected or DATA is addressed.
REQ-013 Write event: wr_now = drw & selected; the block acts only on the cycle where wr_now=1 and wr_now was 0 on the previous cycle, so each drw episode produces exactly one action.
REQ-014 DATA write event with FIFO not full: push dout[7:0]; count increments at that edge.
REQ-015 DATA write event with FIFO full, judged on the pre-edge count: data is dropped, overflow is set to 1, and FIFO contents are unchanged, even if a pop occurs on the same edge.
REQ-016 STATUS write event with dout[3]=1 clears overflow; all other bits are ignored; a simultaneous overflow set is not possible (different register).
REQ-017 FIFO pointers wrap modulo FIFO_DEPTH; count is FIFO_DEPTH when full and 0 when empty.
REQ-018 FSM states: IDLE, START, DATA, STOP.
REQ-019 IDLE with count>0: pop the head into an 8-bit shift register, load the baud counter, go to START; tx=0 from the next cycle.
REQ-020 A push and a pop on the same edge are both performed; count is unchanged.
REQ-021 Each of START, DATA-bit and STOP holds tx for exactly CLKS_PER_BIT cycles; the baud counter counts CLKS_PER_BIT-1 down to 0, then advances.
REQ-022 DATA shifts 8 bits LSB first with a 3-bit bit index; after bit 7, go to STOP (tx=1).
REQ-023 STOP end: go to IDLE for at least 1 cycle; a full frame occupies 10*CLKS_PER_BIT cycles plus 1 idle cycle.
REQ-024 tx is driven from a flop, is glitch-free, and is 1 in IDLE and STOP.
REQ-025 An empty FIFO in IDLE holds tx=1 indefinitely; no pop occurs.

Reset
REQ-026 Reset forces on the next edge: state=IDLE, tx=1, rdata=0, FIFO empty (pointers and count 0), overflow=0, baud counter 0, shift register 0, write-edge history 0.
REQ-027 Reset mid-frame aborts the frame; tx=1 at the next edge; queued bytes are discarded.
REQ-028 Reset dominates simultaneous writes; no push occurs on a reset edge.
REQ-029 The write-edge history is cleared, so a drw held high across reset release produces one event on the first post-reset cycle.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Write DATA 0x55 at address 0x2000, drw high for 3 cycles -> exactly one push; tx low 1 cycle after the push edge; sequence 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; then busy=0.
REQ-031 Read STATUS at 0x2004 after reset -> rdata=0x00000002 one cycle later; address 0x1004 -> rdata=0.
REQ-032 Five back-to-back DATA writes (drw toggled) while the first frame is in flight -> first byte transmitted, 4 queued; fifth write accepted only if a pop has occurred, otherwise overflow=1 and STATUS bit0=1.
REQ-033 Full FIFO plus write on the pop edge -> byte dropped, overflow=1; write STATUS dout=0x8 -> overflow=0.
REQ-034 Assert reset during DATA bit 3 of a frame with 2 bytes queued -> tx=1 next cycle, STATUS=0x02, no further transmission.
REQ-035 Push and pop on the same edge -> count unchanged; the transmitted byte order matches the write order.
